// File: rtl/hs_multi_seeker.sv
// Parallel 2-bit sync-header seeker: each seeker hunts over its own slice of frame offsets,
// and the first to lock wins and stays the winner until it drops lock.
module hs_multi_seeker #(
    parameter int FRAME_W     = 66,
    parameter int NUM_SEEKERS = 2,
    parameter int BUF_W       = 194,
    parameter int LOCK_CNT    = 32,
    parameter int UNLOCK_CNT  = 16,
    parameter int POS_W       = 7,
    localparam int WIN_W      = (NUM_SEEKERS > 1) ? $clog2(NUM_SEEKERS) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [BUF_W-1:0]       gbox_buffer,
    input  logic                   buffer_dv,
    input  logic                   force_resync,
    output logic                   is_synced,
    output logic [POS_W-1:0]       offset_pos,
    output logic [WIN_W-1:0]       winner_idx,
    output logic [NUM_SEEKERS-1:0] seeker_locked,
    output logic                   sync_lost
);

    localparam int SPAN   = FRAME_W / NUM_SEEKERS;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} seek_state_t;

    seek_state_t        state_q [NUM_SEEKERS];
    seek_state_t        state_d [NUM_SEEKERS];
    logic [POS_W-1:0]   pos_q   [NUM_SEEKERS];
    logic [POS_W-1:0]   pos_d   [NUM_SEEKERS];
    logic [GOOD_W-1:0]  good_q  [NUM_SEEKERS];
    logic [GOOD_W-1:0]  good_d  [NUM_SEEKERS];
    logic [BAD_W-1:0]   bad_q   [NUM_SEEKERS];
    logic [BAD_W-1:0]   bad_d   [NUM_SEEKERS];
    logic [NUM_SEEKERS-1:0] hdr_ok;

    logic [NUM_SEEKERS-1:0] locked_now;
    logic                   any_locked;
    logic                   cur_ok;
    logic [WIN_W-1:0]       win_next;
    logic [POS_W-1:0]       offset_next;

    generate
        if (BUF_W > FRAME_W + 1) begin : g_unused
            logic unused_buf;
            assign unused_buf = ^gbox_buffer[BUF_W-1:FRAME_W+1];
        end
    endgenerate

    function automatic logic [POS_W-1:0] advance(input logic [POS_W-1:0] pos, input int k);
        if (pos == POS_W'(k * SPAN + SPAN - 1))
            return POS_W'(k * SPAN);
        return pos + POS_W'(1);
    endfunction

    // Header mux: constant indices only, one compare per owned offset.
    always_comb begin
        hdr_ok = '0;
        for (int k = 0; k < NUM_SEEKERS; k++) begin
            for (int j = 0; j < SPAN; j++) begin
                if (pos_q[k] == POS_W'(k * SPAN + j))
                    hdr_ok[k] = gbox_buffer[k * SPAN + j + 1] ^ gbox_buffer[k * SPAN + j];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NUM_SEEKERS; k++) begin
            if (rst_i) begin
                state_q[k] <= SEARCH;
                pos_q[k]   <= POS_W'(k * SPAN);
                good_q[k]  <= '0;
                bad_q[k]   <= '0;
            end else begin
                state_q[k] <= state_d[k];
                pos_q[k]   <= pos_d[k];
                good_q[k]  <= good_d[k];
                bad_q[k]   <= bad_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SEEKERS; k++) begin
            state_d[k] = state_q[k];
            pos_d[k]   = pos_q[k];
            good_d[k]  = good_q[k];
            bad_d[k]   = bad_q[k];
            if (force_resync) begin
                state_d[k] = SEARCH;
                pos_d[k]   = POS_W'(k * SPAN);
                good_d[k]  = '0;
                bad_d[k]   = '0;
            end else if (buffer_dv) begin
                case (state_q[k])
                    SEARCH: begin
                        if (hdr_ok[k]) begin
                            good_d[k]  = GOOD_W'(1);
                            bad_d[k]   = '0;
                            state_d[k] = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                        end else begin
                            pos_d[k] = advance(pos_q[k], k);
                        end
                    end
                    VERIFY: begin
                        if (hdr_ok[k]) begin
                            good_d[k] = good_q[k] + GOOD_W'(1);
                            if (good_q[k] + GOOD_W'(1) == GOOD_W'(LOCK_CNT)) begin
                                state_d[k] = LOCKED;
                                bad_d[k]   = '0;
                            end
                        end else begin
                            state_d[k] = SEARCH;
                            pos_d[k]   = advance(pos_q[k], k);
                            good_d[k]  = '0;
                        end
                    end
                    LOCKED: begin
                        if (hdr_ok[k]) begin
                            bad_d[k] = '0;
                        end else if (bad_q[k] + BAD_W'(1) == BAD_W'(UNLOCK_CNT)) begin
                            state_d[k] = SEARCH;
                            pos_d[k]   = advance(pos_q[k], k);
                            good_d[k]  = '0;
                            bad_d[k]   = '0;
                        end else begin
                            bad_d[k] = bad_q[k] + BAD_W'(1);
                        end
                    end
                    default: begin
                        state_d[k] = SEARCH;
                        pos_d[k]   = POS_W'(k * SPAN);
                        good_d[k]  = '0;
                        bad_d[k]   = '0;
                    end
                endcase
            end
        end
    end

    // Sticky arbitration: keep the current winner while it stays locked.
    always_comb begin
        locked_now = '0;
        for (int k = 0; k < NUM_SEEKERS; k++)
            locked_now[k] = (state_q[k] == LOCKED);
        any_locked = |locked_now;
        cur_ok = 1'b0;
        for (int k = 0; k < NUM_SEEKERS; k++)
            if (WIN_W'(k) == winner_idx && locked_now[k])
                cur_ok = 1'b1;
        win_next = winner_idx;
        if (!cur_ok)
            for (int k = NUM_SEEKERS - 1; k >= 0; k--)
                if (locked_now[k])
                    win_next = WIN_W'(k);
        offset_next = offset_pos;
        if (any_locked)
            for (int k = 0; k < NUM_SEEKERS; k++)
                if (WIN_W'(k) == win_next)
                    offset_next = pos_q[k];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_synced     <= 1'b0;
            offset_pos    <= '0;
            winner_idx    <= '0;
            seeker_locked <= '0;
            sync_lost     <= 1'b0;
        end else begin
            is_synced     <= any_locked;
            offset_pos    <= offset_next;
            winner_idx    <= win_next;
            seeker_locked <= locked_now;
            sync_lost     <= is_synced & ~any_locked;
        end
    end

endmodule

// File: doc/hs_multi_seeker.md
HS_MULTI_SEEKER -- requirements
Module: hs_multi_seeker

Interface
REQ-001 Parameter FRAME_W, default 66, meaning frame length in bits and number of candidate header offsets.
REQ-002 Parameter NUM_SEEKERS, default 2, meaning number of parallel seekers; FRAME_W % NUM_SEEKERS SHALL be 0, SPAN = FRAME_W/NUM_SEEKERS.
REQ-003 Parameter BUF_W, default 194, meaning gearbox buffer width; BUF_W >= FRAME_W+1 SHALL hold.
REQ-004 Parameter LOCK_CNT, default 32, meaning consecutive valid headers needed to lock.
REQ-005 Parameter UNLOCK_CNT, default 16, meaning consecutive invalid headers needed to drop lock.
REQ-006 Parameter POS_W, default 7, meaning offset width; 2**POS_W >= FRAME_W SHALL hold.
REQ-007 clk_i  input  1  single clock, all logic on rising edge.
REQ-008 rst_i  input  1  reset, synchronous, active-high.
REQ-009 gbox_buffer  input  BUF_W  gearbox buffer view.
REQ-010 buffer_dv  input  1  gbox_buffer valid this cycle.
REQ-011 force_resync  input  1  single-cycle request to restart all seekers.
REQ-012 is_synced  output  1  registered, a locked offset is being reported.
REQ-013 offset_pos  output  POS_W  registered, header offset of the winning seeker.
REQ-014 winner_idx  output  $clog2(NUM_SEEKERS) (min 1)  registered, index of winning seeker.
REQ-015 seeker_locked  output  NUM_SEEKERS  registered, per-seeker LOCKED flag.
REQ-016 sync_lost  output  1  registered one-cycle pulse when is_synced falls.

Function
REQ-017 Header at offset p SHALL be gbox_buffer[p+1:p]; valid iff the two bits differ (2'b01 or 2'b10).
REQ-018 Seeker k SHALL own offsets k*SPAN .. k*SPAN+SPAN-1 and hold pos_k, good_k, bad_k and state in {SEARCH, VERIFY, LOCKED}.
REQ-019 Seeker registers SHALL change only on cycles with buffer_dv=1, except reset and force_resync.
REQ-020 SEARCH: valid header -> VERIFY, good_k=1; invalid -> pos_k advances by 1.
REQ-021 VERIFY: valid header -> good_k+1; when good_k+1 == LOCK_CNT -> LOCKED, bad_k=0; invalid -> SEARCH, pos_k advances, good_k=0.
REQ-022 LOCKED: valid header -> bad_k=0; invalid -> bad_k+1; when bad_k+1 == UNLOCK_CNT -> SEARCH, pos_k advances, counters cleared.
REQ-023 pos_k advance SHALL wrap from k*SPAN+SPAN-1 to k*SPAN.
REQ-024 LOCK_CNT=1 SHALL lock directly from SEARCH on the first valid header.
REQ-025 Arbitration: if seeker winner_idx is LOCKED it SHALL remain winner (sticky); else the lowest-index LOCKED seeker wins; if none, winner_idx holds.
REQ-026 Outputs SHALL register every clock from current seeker state: is_synced = OR of LOCKED flags, offset_pos = pos of arbitrated winner (holds previous value when none locked).
REQ-027 Latency: is_synced SHALL rise on the clock edge after the edge where a seeker enters LOCKED.
REQ-028 sync_lost SHALL be 1 for exactly one cycle when is_synced transitions 1->0; never on reset.
REQ-029 force_resync=1 SHALL put every seeker in SEARCH at pos k*SPAN with counters 0 on that edge, regardless of buffer_dv; outputs follow per REQ-026, including sync_lost pulse if previously synced.
REQ-030 force_resync and rst_i together: rst_i SHALL take priority.

Reset
REQ-031 On rst_i=1: seekers SEARCH, pos_k=k*SPAN, good_k=bad_k=0; is_synced=0, offset_pos=0, winner_idx=0, seeker_locked=0, sync_lost=0.
REQ-032 Reset asserted mid-lock SHALL clear all state on that edge with no sync_lost pulse.

Verification
REQ-033 Defaults, header "01" at offset 5 every dv cycle -> seeker0 locks after 32 dv; is_synced=1, offset_pos=5, winner_idx=0 one cycle later.
REQ-034 Header only at offset 40 -> seeker1 scans 33..40, locks; offset_pos=40, winner_idx=1, seeker_locked=2'b10.
REQ-035 Both offsets 5 and 40 valid, seeker1 locks first -> winner_idx stays 1 after seeker0 locks; seeker_locked=2'b11.
REQ-036 Locked at 40, then 16 consecutive invalid headers -> seeker1 to SEARCH; with seeker0 locked, winner_idx=0, offset_pos=5, no sync_lost; with none locked, is_synced=0, sync_lost one-cycle pulse.
REQ-037 Invalid header on dv 20 of VERIFY at offset 5 -> seeker0 returns to SEARCH at offset 6; no header anywhere: pos wraps 32->0 and 65->33.
REQ-038 force_resync while locked -> next cycle is_synced=0, sync_lost=1, relocks after 32 further valid dv; rst_i during dv gaps clears all outputs to 0.
